// File: rtl/pixel_serial_tx_if.sv
// Pixel input bus for the serial transmitter: DATA_W-bit pixel plus valid/ready.
// Handshake: a word transfers on any rising CLK edge where IN_VALID && IN_READY;
// the master holds IN_DATA stable while IN_VALID is high and not yet accepted.
interface pixel_serial_tx_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] IN_DATA;
  logic              IN_VALID;
  logic              IN_READY;

  modport master (output IN_DATA, output IN_VALID, input IN_READY);
  modport slave  (input IN_DATA, input IN_VALID, output IN_READY);
endinterface

// File: rtl/pixel_serial_tx.sv
// Serial pixel link transmitter: small FIFO feeding a start/data/[parity]/stop framer.
// Optional even parity bit is enabled by defining PIXEL_TX_PARITY_EN.
module pixel_serial_tx #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int CLK_DIV    = 4
) (
  input  logic                          CLK,
  input  logic                          RESETB,
  pixel_serial_tx_if.slave              bus,
  output logic                          TX_SER,
  output logic                          TX_BUSY,
  output logic [$clog2(FIFO_DEPTH):0]   FIFO_COUNT,
  output logic [2:0]                    DBG_STATE
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TMR_W = $clog2(CLK_DIV);
  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
`ifdef PIXEL_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP  = 3'd4
  } state_t;

  state_t            state_q;
  logic [TMR_W-1:0]  timer_q;
  logic [IDX_W-1:0]  bit_idx_q;
  logic [DATA_W-1:0] shift_q;
  logic              tx_ser_q;
  logic              tx_busy_q;
`ifdef PIXEL_TX_PARITY_EN
  logic              parity_q;
`endif

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] head;
  logic              push, pop, bit_end;

  assign bus.IN_READY = (count_q != CNT_FULL);
  assign push         = bus.IN_VALID && bus.IN_READY;
  assign bit_end      = (timer_q == TMR_LAST);
  assign head         = mem_q[rd_ptr_q];
  // Pop only from IDLE or on the final STOP cycle, so back-to-back frames have no gap.
  assign pop          = (count_q != '0) && ((state_q == IDLE) || ((state_q == STOP) && bit_end));

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= bus.IN_DATA;
  end

  always_ff @(posedge CLK or posedge RESETB) begin
    if (RESETB) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge CLK or posedge RESETB) begin
    if (RESETB) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_ser_q  <= 1'b1;
      tx_busy_q <= 1'b0;
`ifdef PIXEL_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else if (pop) begin
      state_q   <= START;
      timer_q   <= '0;
      shift_q   <= head;
      tx_ser_q  <= 1'b0;
      tx_busy_q <= 1'b1;
`ifdef PIXEL_TX_PARITY_EN
      parity_q  <= ^head;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          timer_q   <= '0;
          tx_ser_q  <= 1'b1;
          tx_busy_q <= 1'b0;
        end
        START: begin
          if (bit_end) begin
            state_q   <= DATA;
            timer_q   <= '0;
            bit_idx_q <= '0;
            tx_ser_q  <= shift_q[0];
          end else begin
            timer_q <= timer_q + TMR_W'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            timer_q <= '0;
            if (bit_idx_q == IDX_LAST) begin
`ifdef PIXEL_TX_PARITY_EN
              state_q  <= PARITY;
              tx_ser_q <= parity_q;
`else
              state_q  <= STOP;
              tx_ser_q <= 1'b1;
`endif
            end else begin
              bit_idx_q <= bit_idx_q + IDX_W'(1);
              shift_q   <= shift_q >> 1;
              tx_ser_q  <= shift_q[1];
            end
          end else begin
            timer_q <= timer_q + TMR_W'(1);
          end
        end
`ifdef PIXEL_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            state_q  <= STOP;
            timer_q  <= '0;
            tx_ser_q <= 1'b1;
          end else begin
            timer_q <= timer_q + TMR_W'(1);
          end
        end
`endif
        STOP: begin
          if (bit_end) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            tx_ser_q  <= 1'b1;
            tx_busy_q <= 1'b0;
          end else begin
            timer_q <= timer_q + TMR_W'(1);
          end
        end
        default: begin
          state_q   <= IDLE;
          timer_q   <= '0;
          tx_ser_q  <= 1'b1;
          tx_busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign TX_SER     = tx_ser_q;
  assign TX_BUSY    = tx_busy_q;
  assign FIFO_COUNT = count_q;
  assign DBG_STATE  = state_q;
endmodule

// File: tb/tb_pixel_serial_tx.sv
// Bench for pixel_serial_tx: a frame-level line model (per-cycle level queue) is the reference.
module tb_pixel_serial_tx;
  localparam int DATA_W     = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int CLK_DIV    = 4;
  localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1;
`ifdef PIXEL_TX_PARITY_EN
  localparam int NBITS = DATA_W + 3;
`else
  localparam int NBITS = DATA_W + 2;
`endif
  localparam int FRAME = NBITS * CLK_DIV;

  logic             CLK = 1'b0;
  logic             RESETB = 1'b0;
  logic             TX_SER, TX_BUSY;
  logic [CNT_W-1:0] FIFO_COUNT;
  logic [2:0]       DBG_STATE;

  pixel_serial_tx_if #(.DATA_W(DATA_W)) bus ();

  pixel_serial_tx #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .CLK_DIV(CLK_DIV)) dut (
    .CLK(CLK), .RESETB(RESETB), .bus(bus),
    .TX_SER(TX_SER), .TX_BUSY(TX_BUSY), .FIFO_COUNT(FIFO_COUNT), .DBG_STATE(DBG_STATE)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              par;
  } vec_t;

  vec_t              vecs[6];
  logic [DATA_W-1:0] exp_q[$];   // words the model holds in its FIFO
  logic              line_q[$];  // expected line level for each remaining cycle of the frame
  logic              cap_ser[$];
  logic              cap_busy[$];
  int                n_checks = 0;
  int                n_fail = 0;
  int                both_seen = 0;
  int                ready_low = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic build_frame(input logic [DATA_W-1:0] d);
    repeat (CLK_DIV) line_q.push_back(1'b0);
    for (int b = 0; b < DATA_W; b++) repeat (CLK_DIV) line_q.push_back(d[b]);
`ifdef PIXEL_TX_PARITY_EN
    repeat (CLK_DIV) line_q.push_back(^d);
`endif
    repeat (CLK_DIV) line_q.push_back(1'b1);
  endtask

  // Advance the model across one rising edge with the given inputs.
  task automatic model_step(input logic v, input logic [DATA_W-1:0] d);
    bit acc;
    bit popped;
    acc = v && (exp_q.size() < FIFO_DEPTH);
    popped = 0;
    if (line_q.size() != 0) void'(line_q.pop_front());
    if (line_q.size() == 0 && exp_q.size() != 0) begin
      build_frame(exp_q.pop_front());
      popped = 1;
    end
    if (acc && popped) both_seen++;
    if (acc) exp_q.push_back(d);
  endtask

  // Called at a falling edge; returns at the next falling edge after checking.
  task automatic cycle(input logic v, input logic [DATA_W-1:0] d);
    bus.IN_VALID = v;
    bus.IN_DATA  = d;
    model_step(v, d);
    @(posedge CLK);
    @(negedge CLK);
    check("tx_ser", 32'(TX_SER), 32'(line_q.size() != 0 ? line_q[0] : 1'b1));
    check("tx_busy", 32'(TX_BUSY), 32'(line_q.size() != 0));
    check("fifo_count", 32'(FIFO_COUNT), 32'(exp_q.size()));
    check("in_ready", 32'(bus.IN_READY), 32'(exp_q.size() < FIFO_DEPTH));
    if (!bus.IN_READY) ready_low++;
    cap_ser.push_back(TX_SER);
    cap_busy.push_back(TX_BUSY);
  endtask

  task automatic push_word(input logic [DATA_W-1:0] d);
    int guard;
    bit done;
    guard = 0;
    done = 0;
    while (!done && guard < 2000) begin
      done = bus.IN_READY;
      cycle(1'b1, d);
      guard++;
    end
    bus.IN_VALID = 1'b0;
    check("push_timeout", 32'(done), 32'd1);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((line_q.size() != 0 || exp_q.size() != 0) && guard < 5000) begin
      cycle(1'b0, '0);
      guard++;
    end
    check("drain_timeout", 32'(guard < 5000), 32'd1);
  endtask

  function automatic int busy_total();
    int n;
    n = 0;
    foreach (cap_busy[i]) if (cap_busy[i]) n++;
    return n;
  endfunction

  function automatic int busy_rises();
    int n;
    logic prev;
    n = 0;
    prev = 1'b0;
    foreach (cap_busy[i]) begin
      if (cap_busy[i] && !prev) n++;
      prev = cap_busy[i];
    end
    return n;
  endfunction

  initial begin
    logic [DATA_W-1:0] got;
    vecs[0] = '{8'hA5, 1'b0};
    vecs[1] = '{8'h07, 1'b1};
    vecs[2] = '{8'h00, 1'b0};
    vecs[3] = '{8'hFF, 1'b0};
    vecs[4] = '{8'h3C, 1'b0};
    vecs[5] = '{8'h01, 1'b1};

    bus.IN_VALID = 1'b0;
    bus.IN_DATA  = '0;
    #1 RESETB = 1'b1;
    @(negedge CLK);
    check("rst_tx_ser", 32'(TX_SER), 32'd1);
    check("rst_tx_busy", 32'(TX_BUSY), 32'd0);
    check("rst_fifo_count", 32'(FIFO_COUNT), 32'd0);
    check("rst_in_ready", 32'(bus.IN_READY), 32'd1);
    check("rst_state", 32'(DBG_STATE), 32'd0);
    RESETB = 1'b0;

    // Single frames: decode the captured line and compare to the table.
    for (int i = 0; i < 6; i++) begin
      cap_ser.delete();
      cap_busy.delete();
      push_word(vecs[i].data);
      drain();
      check("latency_idle", 32'(cap_ser[0]), 32'd1);
      check("latency_start", 32'(cap_ser[1]), 32'd0);
      check("start_bit", 32'(cap_ser[1 + CLK_DIV / 2]), 32'd0);
      for (int b = 0; b < DATA_W; b++) got[b] = cap_ser[1 + (b + 1) * CLK_DIV + CLK_DIV / 2];
      check("frame_data", 32'(got), 32'(vecs[i].data));
`ifdef PIXEL_TX_PARITY_EN
      check("frame_parity", 32'(cap_ser[1 + (DATA_W + 1) * CLK_DIV + CLK_DIV / 2]), 32'(vecs[i].par));
`endif
      check("stop_bit", 32'(cap_ser[1 + (NBITS - 1) * CLK_DIV + CLK_DIV / 2]), 32'd1);
      check("frame_busy_cycles", 32'(busy_total()), 32'(FRAME));
    end

    // Six words with valid held: FIFO fills, frames run back to back.
    cap_ser.delete();
    cap_busy.delete();
    ready_low = 0;
    for (int k = 1; k <= 6; k++) push_word(DATA_W'(k));
    drain();
    check("burst_ready_dropped", 32'(ready_low > 0), 32'd1);
    check("burst_busy_cycles", 32'(busy_total()), 32'(6 * FRAME));
    check("burst_busy_contiguous", 32'(busy_rises()), 32'd1);

    // Reset mid-frame with two words queued.
    cap_busy.delete();
    push_word(8'h3C);
    push_word(8'h11);
    push_word(8'h22);
    repeat (13) cycle(1'b0, '0);
    check("pre_reset_busy", 32'(TX_BUSY), 32'd1);
    #2 RESETB = 1'b1;
    #1;
    check("async_rst_tx_ser", 32'(TX_SER), 32'd1);
    check("async_rst_busy", 32'(TX_BUSY), 32'd0);
    check("async_rst_count", 32'(FIFO_COUNT), 32'd0);
    check("async_rst_ready", 32'(bus.IN_READY), 32'd1);
    exp_q.delete();
    line_q.delete();
    @(negedge CLK);
    @(negedge CLK);
    RESETB = 1'b0;
    cap_busy.delete();
    repeat (30) cycle(1'b0, '0);
    check("post_reset_quiet", 32'(busy_total()), 32'd0);
    push_word(8'h5A);
    drain();

    // Pointer wrap: ten words at an absorbable pace.
    for (int k = 0; k < 10; k++) begin
      push_word(8'h80 + DATA_W'(k));
      repeat ($urandom_range(0, 12)) cycle(1'b0, '0);
    end
    drain();

    // Random traffic against the line model.
    for (int n = 0; n < 600; n++) begin
      cycle(1'($urandom_range(0, 3) != 0), DATA_W'($urandom));
    end
    bus.IN_VALID = 1'b0;
    drain();
    check("push_pop_same_edge_seen", 32'(both_seen > 0), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/pixel_serial_tx.md
Name: pixel_serial_tx

Overview:
- Transmit end of the serial pixel link for the edge-detection ASIC.
- Accepts processed DATA_W-bit pixels over a valid/ready handshake and buffers them in a small FIFO.
- Serializes each pixel LSB-first in an asynchronous-style frame: start bit, data, optional parity, stop bit.
- Sits between the edge-filter output stage and the chip output pad; it is the counterpart of the receive-side deserializer.

Parameters:
- DATA_W, 8, pixel width in bits.
- FIFO_DEPTH, 4, FIFO entries; must be a power of 2, at least 2.
- CLK_DIV, 4, CLK cycles per serial bit; must be at least 2.

Ports:
- CLK  input  1  clock, rising-edge.
- RESETB  input  1  reset, asynchronous, active-high.
- IN_DATA  input  DATA_W  pixel to send.
- IN_VALID  input  1  IN_DATA valid.
- IN_READY  output  1  FIFO can accept; a push occurs on a rising edge where IN_VALID&IN_READY.
- TX_SER  output  1  serial line; idles high.
- TX_BUSY  output  1  high while a frame is on the line (START through STOP).
- FIFO_COUNT  output  clog2(FIFO_DEPTH)+1  entries currently buffered.

Behaviour:
- Reset is RESETB, asynchronous, active-high; clock is CLK. Reset values:
  - TX_SER=1, TX_BUSY=0, FIFO_COUNT=0, IN_READY=1.
  - State IDLE; bit timer and bit index are 0.
- All outputs are registered except IN_READY, which is (FIFO_COUNT != FIFO_DEPTH) decoded from the registered count.
- FIFO:
  - Circular buffer with read/write pointers that wrap modulo FIFO_DEPTH.
  - Push when IN_VALID&IN_READY; pop when the FSM leaves IDLE or STOP for START with the FIFO non-empty.
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - When full, IN_READY=0 and IN_DATA is ignored. A pop while full raises IN_READY on the next cycle.
  - Pop while empty never occurs.
- FSM states: IDLE, START, DATA, PARITY (only when the option is enabled), STOP.
  - IDLE: TX_SER=1. If FIFO_COUNT!=0, pop into shift register, go to START, and clear the timer.
  - START: TX_SER=0 for CLK_DIV cycles, then DATA with bit index 0.
  - DATA: TX_SER=shift[0] for CLK_DIV cycles per bit, shifting right after each bit. After bit DATA_W-1, go to PARITY if enabled, else STOP.
  - STOP: TX_SER=1 for CLK_DIV cycles. At the last cycle: if FIFO non-empty, pop and go to START directly (no idle gap); else go to IDLE.
  - TX_BUSY=1 in every state except IDLE.
- Timing:
  - Latency: a push at edge N into an empty FIFO with FSM in IDLE drives TX_SER low at edge N+1.
  - Frame length is (DATA_W+2)*CLK_DIV cycles, or (DATA_W+3)*CLK_DIV with parity.
  - Bit timer counts 0..CLK_DIV-1; a bit boundary occurs when the timer equals CLK_DIV-1.
- A push arriving during a frame is buffered and does not disturb the current frame.
- Reset asserted mid-frame:
  - TX_SER returns to 1 immediately (asynchronously).
  - The FIFO is flushed (pointers and count cleared) and the partial frame is abandoned.
  - After reset release the line stays idle until the next push.

Optional Feature:
- Macro: PIXEL_TX_PARITY_EN.
- Defined:
  - PARITY state is inserted between DATA and STOP.
  - TX_SER carries the even-parity bit (XOR of all DATA_W data bits) for CLK_DIV cycles.
  - The parity value is computed at pop time and held in a register.
- Undefined:
  - No PARITY state or parity register exists; DATA goes directly to STOP.
  - Frame is (DATA_W+2)*CLK_DIV cycles.

Test Plan:
1. Reset, then push 0xA5 once (CLK_DIV=4, no parity) -> TX_SER sequence 0,1,0,1,0,0,1,0,1,1, each level held 4 cycles; TX_BUSY high for exactly 40 cycles; TX_SER low at the edge after the push.
2. Hold IN_VALID with 0x01,0x02,...,0x06 while the line is busy -> IN_READY drops once FIFO_COUNT=4; all 6 bytes are sent in order with no idle cycles between frames (STOP goes directly to START); TX_BUSY stays high for 240 cycles.
3. FIFO full plus the pop cycle: push on the same edge the FSM pops -> FIFO_COUNT holds at 4 only when IN_READY was 1; the ignored word never appears on the line.
4. Assert RESETB at cycle 15 of a frame carrying 0x3C with 2 words queued -> TX_SER=1 asynchronously, FIFO_COUNT=0, TX_BUSY=0; no further frames after release until a new push.
5. PIXEL_TX_PARITY_EN defined, push 0x07 -> parity bit 1 inserted after data; frame is 44 cycles; 0x00 gives parity 0.
6. Pointer wrap: 10 consecutive pushes of 0x80..0x89 at a pace the FIFO absorbs -> output matches input order across both pointer wraps.
